// File: rtl/sram_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, defaults, byte-enable helper.
// latency: n/a; backpressure: n/a.
package sram_arbiter_pkg;

  localparam int          STARVE_LIM_DEF = 4;
  localparam logic [3:0]  BE_ALL         = 4'hF;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_I_ADDR = 3'd1,
    ARB_D_ADDR = 3'd2,
    ARB_I_WAIT = 3'd3,
    ARB_D_WAIT = 3'd4
  } arb_state_t;

  // Stores drive their own enables; loads always fetch the full word.
  function automatic logic [3:0] bus_be(input logic [3:0] we);
    return (|we) ? we : BE_ALL;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// External SRAM-like bus: req/addr_ok/data_ok handshake, one transaction outstanding.
// latency: n/a; backpressure: master holds m_req and fields until m_addr_ok.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_wr;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_req, m_wr, m_be, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  modport slave (
    input  m_req, m_wr, m_be, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/sram_arbiter_starve_ctr.sv
// Saturating count of data grants that overtook a waiting fetch.
// latency: 1 cycle inc/clr to sat; backpressure: none, holds at LIM.
module sram_arbiter_starve_ctr #(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CW = (LIM < 1) ? 1 : $clog2(LIM + 1);

  logic [CW-1:0] cnt_q;

  assign sat = (cnt_q == CW'(LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM bus port between the fetch and load/store paths, one transaction at a time.
// latency: req to ready >= 2 cycles; backpressure: stallreq_mem while a request is unanswered.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              flush,
  output logic              stallreq_mem,
  sram_arbiter_if.master    bus
);

  arb_state_t        state_q, state_d;
  logic              i_elig, d_elig;
  logic              grant_i, grant_d;
  logic              starve_sat;
  logic              drop_q, drop_d;
  logic              i_done, d_done;

  logic              m_wr_q;
  logic [3:0]        m_be_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic              i_ready_q, d_ready_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  // A requester whose completion pulse is up this cycle is not asking again yet.
  assign i_elig = i_req & ~i_ready_q;
  assign d_elig = d_req & ~d_ready_q;

  assign stallreq_mem = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    drop_d  = drop_q;
    i_done  = 1'b0;
    d_done  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        drop_d = 1'b0;
        if (i_elig && !flush && (starve_sat || !d_elig)) begin
          grant_i = 1'b1;
          state_d = ARB_I_ADDR;
        end else if (d_elig) begin
          grant_d = 1'b1;
          state_d = ARB_D_ADDR;
        end
      end
      ARB_I_ADDR: begin
        if (bus.m_addr_ok) begin
          if (bus.m_data_ok) begin
            i_done  = ~flush;
            state_d = ARB_IDLE;
          end else begin
            // Address already taken by the bus: data must still be drained.
            drop_d  = flush;
            state_d = ARB_I_WAIT;
          end
        end else if (flush) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_D_ADDR: begin
        if (bus.m_addr_ok) begin
          if (bus.m_data_ok) begin
            d_done  = 1'b1;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_D_WAIT;
          end
        end
      end
      ARB_I_WAIT: begin
        drop_d = drop_q | flush;
        if (bus.m_data_ok) begin
          i_done  = ~(drop_q | flush);
          state_d = ARB_IDLE;
        end
      end
      ARB_D_WAIT: begin
        if (bus.m_data_ok) begin
          d_done  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= ARB_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      m_wr_q    <= 1'b0;
      m_be_q    <= 4'h0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else if (grant_i) begin
      m_wr_q    <= 1'b0;
      m_be_q    <= BE_ALL;
      m_addr_q  <= i_addr;
      m_wdata_q <= '0;
    end else if (grant_d) begin
      m_wr_q    <= |d_we;
      m_be_q    <= bus_be(d_we);
      m_addr_q  <= d_addr;
      m_wdata_q <= (|d_we) ? d_wdata : '0;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ready_q <= i_done;
      d_ready_q <= d_done;
      if (i_done) begin
        i_rdata_q <= bus.m_rdata;
      end
      if (d_done) begin
        d_rdata_q <= m_wr_q ? '0 : bus.m_rdata;
      end
    end
  end

  sram_arbiter_starve_ctr #(
    .LIM (STARVE_LIM)
  ) u_starve (
    .clk   (cpu_clk_50M),
    .rst_n (cpu_rst_n),
    .inc   (grant_d & i_elig),
    .clr   (grant_i),
    .sat   (starve_sat)
  );

  assign bus.m_req   = (state_q == ARB_I_ADDR) || (state_q == ARB_D_ADDR);
  assign bus.m_wr    = m_wr_q;
  assign bus.m_be    = m_be_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;

  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_sram_arbiter;
  localparam int LIM = 4;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n   = 1'b0;
  logic        i_req   = 1'b0;
  logic [31:0] i_addr  = '0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req   = 1'b0;
  logic [3:0]  d_we    = '0;
  logic [31:0] d_addr  = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        flush   = 1'b0;
  logic        stallreq_mem;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(LIM)) dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_ready      (i_ready),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_ready      (d_ready),
    .flush        (flush),
    .stallreq_mem (stallreq_mem),
    .bus          (bus)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one in-flight transaction record plus a starvation tally.
  bit          mb_busy, mb_acc, mb_own_d, mb_drop;
  logic [31:0] t_addr, t_wdata;
  logic        t_wr;
  logic [3:0]  t_be;
  int          starve;
  bit          e_i_ready, e_d_ready;
  logic [31:0] e_i_rdata, e_d_rdata;

  task automatic model_reset();
    mb_busy = 0; mb_acc = 0; mb_own_d = 0; mb_drop = 0;
    t_addr = '0; t_wdata = '0; t_wr = 1'b0; t_be = '0;
    starve = 0; e_i_ready = 0; e_d_ready = 0;
    e_i_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic model_step();
    bit i_el, d_el, done, n_ir, n_dr;
    if (!cpu_rst_n) begin
      model_reset();
      return;
    end
    n_ir = 0; n_dr = 0; done = 0;
    i_el = i_req && !e_i_ready;
    d_el = d_req && !e_d_ready;
    if (!mb_busy) begin
      if (i_el && !flush && (starve == LIM || !d_el)) begin
        mb_busy = 1; mb_acc = 0; mb_own_d = 0; mb_drop = 0;
        t_addr = i_addr; t_wr = 1'b0; t_be = 4'hF; t_wdata = '0;
        starve = 0;
      end else if (d_el) begin
        mb_busy = 1; mb_acc = 0; mb_own_d = 1; mb_drop = 0;
        t_addr = d_addr; t_wr = (d_we != 4'h0);
        t_be = t_wr ? d_we : 4'hF;
        t_wdata = t_wr ? d_wdata : 32'h0;
        if (i_el && starve < LIM) starve++;
      end
    end else if (!mb_acc) begin
      if (bus.m_addr_ok) begin
        if (!mb_own_d && flush) mb_drop = 1;
        if (bus.m_data_ok) done = 1;
        else mb_acc = 1;
      end else if (!mb_own_d && flush) begin
        mb_busy = 0;
      end
    end else begin
      if (!mb_own_d && flush) mb_drop = 1;
      if (bus.m_data_ok) done = 1;
    end
    if (done) begin
      mb_busy = 0; mb_acc = 0;
      if (mb_own_d) begin
        n_dr = 1;
        e_d_rdata = t_wr ? 32'h0 : bus.m_rdata;
      end else if (!mb_drop) begin
        n_ir = 1;
        e_i_rdata = bus.m_rdata;
      end
    end
    e_i_ready = n_ir;
    e_d_ready = n_dr;
  endtask

  task automatic check_outputs();
    bit e_mreq;
    e_mreq = mb_busy && !mb_acc;
    chk("stallreq", 32'(stallreq_mem), 32'((i_req && !e_i_ready) || (d_req && !e_d_ready)));
    chk("i_ready", 32'(i_ready), 32'(e_i_ready));
    chk("d_ready", 32'(d_ready), 32'(e_d_ready));
    chk("m_req", 32'(bus.m_req), 32'(e_mreq));
    if (e_i_ready) chk("i_rdata", i_rdata, e_i_rdata);
    if (e_d_ready) chk("d_rdata", d_rdata, e_d_rdata);
    if (e_mreq || !cpu_rst_n) begin
      chk("m_addr", bus.m_addr, t_addr);
      chk("m_wr", 32'(bus.m_wr), 32'(t_wr));
      chk("m_be", 32'(bus.m_be), 32'(t_be));
      chk("m_wdata", bus.m_wdata, t_wdata);
    end
  endtask

  // Inputs are set at a falling edge; this consumes them at the next rising edge.
  task automatic tick();
    model_step();
    @(negedge cpu_clk_50M);
    check_outputs();
  endtask

  bit mem_out = 0;
  int mem_cnt = 0;

  task automatic drive_rand();
    if (i_ready) begin
      i_req  = ($urandom_range(0, 3) != 0);
      i_addr = $urandom & 32'hFFFF_FFFC;
    end else if (!i_req && $urandom_range(0, 3) == 0) begin
      i_req  = 1'b1;
      i_addr = $urandom & 32'hFFFF_FFFC;
    end
    flush = ($urandom_range(0, 15) == 0);
    if (flush && i_req) i_addr = $urandom & 32'hFFFF_FFFC;
    if (d_ready || (!d_req && $urandom_range(0, 2) == 0)) begin
      d_req   = d_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
    end
    bus.m_rdata   = $urandom;
    bus.m_addr_ok = 1'b0;
    bus.m_data_ok = 1'b0;
    if (mem_out) begin
      if (mem_cnt == 0) begin
        bus.m_data_ok = 1'b1;
        mem_out = 0;
      end else begin
        mem_cnt--;
      end
    end else if (bus.m_req) begin
      if ($urandom_range(0, 2) != 0) begin
        bus.m_addr_ok = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          bus.m_data_ok = 1'b1;
        end else begin
          mem_out = 1;
          mem_cnt = $urandom_range(0, 3);
        end
      end else begin
        bus.m_data_ok = ($urandom_range(0, 5) == 0);
      end
    end else begin
      bus.m_data_ok = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic bus_idle();
    bus.m_addr_ok = 1'b0;
    bus.m_data_ok = 1'b0;
  endtask

  logic [31:0] t3_exp [7];
  logic [31:0] t3_got [$];

  initial begin
    bit prev_req;
    bus.m_addr_ok = 1'b0;
    bus.m_data_ok = 1'b0;
    bus.m_rdata   = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_m_req", 32'(bus.m_req), 32'h0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_i_ready", 32'(i_ready), 32'h0);
    cpu_rst_n = 1'b1;
    tick();

    // 1: minimum-latency fetch
    i_req = 1'b1; i_addr = 32'h0000_1000;
    tick();
    chk("t1_m_req", 32'(bus.m_req), 32'h1);
    bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h2402_0001;
    tick();
    chk("t1_i_ready", 32'(i_ready), 32'h1);
    chk("t1_i_rdata", i_rdata, 32'h2402_0001);
    i_req = 1'b0; bus_idle();
    tick();

    // 2: data beats fetch, then fetch follows
    i_req = 1'b1; i_addr = 32'h0000_2000;
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h8000_0010; d_wdata = 32'hA5A5_1234;
    tick();
    chk("t2_m_wr", 32'(bus.m_wr), 32'h1);
    chk("t2_m_be", 32'(bus.m_be), 32'h3);
    chk("t2_m_addr", bus.m_addr, 32'h8000_0010);
    bus.m_addr_ok = 1'b1;
    tick();
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1;
    tick();
    chk("t2_d_ready", 32'(d_ready), 32'h1);
    d_req = 1'b0; bus_idle();
    tick();
    chk("t2_fetch_addr", bus.m_addr, 32'h0000_2000);
    bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h1111_2222;
    tick();
    i_req = 1'b0; bus_idle();
    tick();

    // 3: fetch forced through after LIM overtaking data grants
    t3_exp = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h3000, 32'h4000, 32'h4000};
    i_req = 1'b1; i_addr = 32'h3000;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h4000;
    prev_req = 1'b0;
    for (int c = 0; c < 80 && t3_got.size() < 7; c++) begin
      bus.m_addr_ok = bus.m_req; bus.m_data_ok = bus.m_req;
      bus.m_rdata = $urandom;
      flush = d_ready;
      tick();
      if (bus.m_req && !prev_req) t3_got.push_back(bus.m_addr);
      prev_req = bus.m_req;
    end
    chk("t3_grants", 32'(t3_got.size()), 32'd7);
    for (int k = 0; k < t3_got.size() && k < 7; k++) chk("t3_order", t3_got[k], t3_exp[k]);
    flush = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (d_ready) d_req = 1'b0;
      if (i_ready) i_req = 1'b0;
      bus.m_addr_ok = bus.m_req; bus.m_data_ok = bus.m_req;
      tick();
    end
    bus_idle(); i_req = 1'b0; d_req = 1'b0;
    tick();

    // 4: flush while waiting for fetch data
    i_req = 1'b1; i_addr = 32'h5000;
    tick();
    bus.m_addr_ok = 1'b1;
    tick();
    bus.m_addr_ok = 1'b0; flush = 1'b1; i_addr = 32'h6000;
    tick();
    flush = 1'b0;
    tick(); tick();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t4_no_ready", 32'(i_ready), 32'h0);
    bus_idle();
    tick();
    chk("t4_new_addr", bus.m_addr, 32'h6000);
    bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0C00_0123;
    tick();
    chk("t4_ready", 32'(i_ready), 32'h1);
    i_req = 1'b0; bus_idle();
    tick();

    // 5: address phase stretched by the bus
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h7000;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_m_req", 32'(bus.m_req), 32'h1);
      chk("t5_m_addr", bus.m_addr, 32'h7000);
      chk("t5_stall", 32'(stallreq_mem), 32'h1);
    end
    bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h7777_0000;
    tick();
    chk("t5_d_ready", 32'(d_ready), 32'h1);
    d_req = 1'b0; bus_idle();
    tick();

    // 6: reset in the data wait phase, stale data_ok afterwards
    d_req = 1'b1; d_we = 4'hF; d_addr = 32'h9000; d_wdata = 32'h1234_5678;
    tick();
    bus.m_addr_ok = 1'b1;
    tick();
    cpu_rst_n = 1'b0; bus_idle(); d_req = 1'b0;
    tick();
    chk("t6_m_req", 32'(bus.m_req), 32'h0);
    chk("t6_m_wr", 32'(bus.m_wr), 32'h0);
    chk("t6_m_be", 32'(bus.m_be), 32'h0);
    chk("t6_m_addr", bus.m_addr, 32'h0);
    chk("t6_m_wdata", bus.m_wdata, 32'h0);
    chk("t6_i_rdata", i_rdata, 32'h0);
    chk("t6_stall", 32'(stallreq_mem), 32'h0);
    cpu_rst_n = 1'b1;
    tick();
    bus.m_data_ok = 1'b1;
    tick();
    chk("t6_no_ready", 32'(d_ready), 32'h0);
    bus_idle();
    tick();

    // Randomized traffic
    mem_out = 0;
    for (int c = 0; c < 4000; c++) begin
      drive_rand();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
